// File: rtl/address_bus_ws_m.sv
// rtl/address_bus_ws_m.sv - parametrised 6502 address decoder with per-region wait-state stretching
// Optional sticky unmapped-access capture is enabled by defining ADDRESS_BUS_WS_BUS_ERROR_EN.
module address_bus_ws_m #(
    parameter logic [15:0] RAM_END      = 16'h36ff,
    parameter logic [15:0] VRAM_END     = 16'h3fff,
    parameter logic [15:0] FIRMWARE_END = 16'h6fff,
    parameter logic [15:0] IO_BASE      = 16'h7000,
    parameter int          IO_COUNT     = 4,
    parameter logic [15:0] ROM_BASE     = 16'h8000,
    parameter logic [15:0] VECTORS_BASE = 16'hfffa,
    parameter int          WS_RAM       = 0,
    parameter int          WS_VRAM      = 1,
    parameter int          WS_FIRMWARE  = 0,
    parameter int          WS_ROM       = 2,
    parameter int          WS_IO        = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [15:0]         cpu_address,
    input  logic                cpu_valid,
    output logic                cpu_rdy,
    output logic                SELECT_ram,
    output logic                SELECT_vram,
    output logic                SELECT_firmware,
    output logic                SELECT_rom,
    output logic                SELECT_vectors,
    output logic [IO_COUNT-1:0] SELECT_io,
    output logic                SELECT_unmapped
`ifdef ADDRESS_BUS_WS_BUS_ERROR_EN
    ,
    input  logic                bus_error_clr,
    output logic                bus_error_irq,
    output logic [15:0]         bus_error_address
`endif
);

    localparam logic [16:0] IO_LIMIT = 17'(IO_BASE) + 17'(IO_COUNT);

    localparam logic [2:0] WS_RAM_L      = 3'(WS_RAM);
    localparam logic [2:0] WS_VRAM_L     = 3'(WS_VRAM);
    localparam logic [2:0] WS_FIRMWARE_L = 3'(WS_FIRMWARE);
    localparam logic [2:0] WS_ROM_L      = 3'(WS_ROM);
    localparam logic [2:0] WS_IO_L       = 3'(WS_IO);

`ifdef SIM
    if (!((RAM_END < VRAM_END) && (VRAM_END < FIRMWARE_END) && (FIRMWARE_END < IO_BASE) &&
          (IO_LIMIT <= 17'(ROM_BASE)) && (ROM_BASE <= VECTORS_BASE) &&
          (IO_COUNT >= 1) && (IO_COUNT <= 16))) begin : g_bad_map
        $error("address_bus_ws_m: illegal memory map parameters");
    end
    if ((WS_RAM > 7) || (WS_VRAM > 7) || (WS_FIRMWARE > 7) || (WS_ROM > 7) || (WS_IO > 7) ||
        (WS_RAM < 0) || (WS_VRAM < 0) || (WS_FIRMWARE < 0) || (WS_ROM < 0) || (WS_IO < 0)) begin : g_bad_ws
        $error("address_bus_ws_m: wait-state parameter outside 0..7");
    end
`endif

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    logic                w_is_ram;
    logic                w_is_vram;
    logic                w_is_fw;
    logic                w_is_io;
    logic                w_is_rom;
    logic                w_is_vec;
    logic                w_is_unm;
    logic [15:0]         w_io_off;
    logic [IO_COUNT-1:0] w_io_sel;
    logic [2:0]          w_ws;

    state_t              r_state;
    state_t              w_next_state;
    logic [2:0]          r_count;
    logic [2:0]          w_next_count;

    // Region decode; any hole between firmware and I/O also falls into unmapped.
    assign w_is_ram  = (cpu_address <= RAM_END);
    assign w_is_vram = (cpu_address > RAM_END) && (cpu_address <= VRAM_END);
    assign w_is_fw   = (cpu_address > VRAM_END) && (cpu_address <= FIRMWARE_END);
    assign w_is_io   = (cpu_address >= IO_BASE) && ({1'b0, cpu_address} < IO_LIMIT);
    assign w_is_rom  = (cpu_address >= ROM_BASE);
    assign w_is_vec  = (cpu_address >= VECTORS_BASE);
    assign w_is_unm  = !(w_is_ram || w_is_vram || w_is_fw || w_is_io || w_is_rom);
    assign w_io_off  = cpu_address - IO_BASE;

    always_comb begin
        w_io_sel = '0;
        for (int i = 0; i < IO_COUNT; i++) begin
            w_io_sel[i] = w_is_io && (w_io_off == 16'(i));
        end
    end

    always_comb begin
        w_ws = 3'd0;
        if (w_is_ram) begin
            w_ws = WS_RAM_L;
        end else if (w_is_vram) begin
            w_ws = WS_VRAM_L;
        end else if (w_is_fw) begin
            w_ws = WS_FIRMWARE_L;
        end else if (w_is_io) begin
            w_ws = WS_IO_L;
        end else if (w_is_rom) begin
            w_ws = WS_ROM_L;
        end
    end

    assign SELECT_ram      = w_is_ram;
    assign SELECT_vram     = w_is_vram;
    assign SELECT_firmware = w_is_fw;
    assign SELECT_rom      = w_is_rom;
    assign SELECT_vectors  = w_is_rom && w_is_vec;
    assign SELECT_io       = w_io_sel;
    assign SELECT_unmapped = w_is_unm;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_count <= 3'd0;
        end else begin
            r_state <= w_next_state;
            r_count <= w_next_count;
        end
    end

    // The address cycle itself is the first stall cycle, so WAIT is entered with ws-1 remaining.
    always_comb begin
        w_next_state = r_state;
        w_next_count = r_count;
        case (r_state)
            S_IDLE: begin
                if (cpu_valid && (w_ws != 3'd0)) begin
                    w_next_state = S_WAIT;
                    w_next_count = w_ws - 3'd1;
                end
            end
            S_WAIT: begin
                if (r_count != 3'd0) begin
                    w_next_count = r_count - 3'd1;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_count = 3'd0;
            end
        endcase
    end

    always_comb begin
        cpu_rdy = 1'b1;
        if (!rst) begin
            case (r_state)
                S_IDLE:  cpu_rdy = !cpu_valid || (w_ws == 3'd0);
                S_WAIT:  cpu_rdy = (r_count == 3'd0);
                default: cpu_rdy = 1'b1;
            endcase
        end
    end

`ifdef ADDRESS_BUS_WS_BUS_ERROR_EN
    logic        w_bus_err;
    logic        r_irq;
    logic [15:0] r_err_addr;

    assign w_bus_err = cpu_valid && w_is_unm && cpu_rdy;

    // First error address is kept until cleared; a clear coinciding with a new error re-arms capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq      <= 1'b0;
            r_err_addr <= 16'h0000;
        end else if (w_bus_err) begin
            r_irq <= 1'b1;
            if (!r_irq || bus_error_clr) begin
                r_err_addr <= cpu_address;
            end
        end else if (bus_error_clr) begin
            r_irq <= 1'b0;
        end
    end

    assign bus_error_irq     = r_irq;
    assign bus_error_address = r_err_addr;
`endif

endmodule

// File: tb/tb_address_bus_ws_m.sv
// tb/tb_address_bus_ws_m.sv - randomized self-checking bench for address_bus_ws_m against a region-level model
module tb_address_bus_ws_m;

    logic        clk;
    logic        rst;
    logic [15:0] addr1, addr2;
    logic        valid1, valid2;
    logic        rdy1, rdy2;
    logic        ram1, vram1, fw1, rom1, vec1, unm1;
    logic        ram2, vram2, fw2, rom2, vec2, unm2;
    logic [3:0]  io1;
    logic [7:0]  io2;
`ifdef ADDRESS_BUS_WS_BUS_ERROR_EN
    logic        clr;
    logic        irq1, irq2;
    logic [15:0] eaddr1, eaddr2;
`endif

    int total = 0;
    int bad   = 0;

    address_bus_ws_m u_dut (
        .clk(clk), .rst(rst), .cpu_address(addr1), .cpu_valid(valid1), .cpu_rdy(rdy1),
        .SELECT_ram(ram1), .SELECT_vram(vram1), .SELECT_firmware(fw1), .SELECT_rom(rom1),
        .SELECT_vectors(vec1), .SELECT_io(io1), .SELECT_unmapped(unm1)
`ifdef ADDRESS_BUS_WS_BUS_ERROR_EN
        , .bus_error_clr(clr), .bus_error_irq(irq1), .bus_error_address(eaddr1)
`endif
    );

    address_bus_ws_m #(.IO_COUNT(8), .WS_IO(3)) u_dut8 (
        .clk(clk), .rst(rst), .cpu_address(addr2), .cpu_valid(valid2), .cpu_rdy(rdy2),
        .SELECT_ram(ram2), .SELECT_vram(vram2), .SELECT_firmware(fw2), .SELECT_rom(rom2),
        .SELECT_vectors(vec2), .SELECT_io(io2), .SELECT_unmapped(unm2)
`ifdef ADDRESS_BUS_WS_BUS_ERROR_EN
        , .bus_error_clr(clr), .bus_error_irq(irq2), .bus_error_address(eaddr2)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Select vector layout: {ram, vram, fw, rom, vectors, unmapped, io[15:0]}
    logic [21:0] got1, got2;
    assign got1 = {ram1, vram1, fw1, rom1, vec1, unm1, 12'h000, io1};
    assign got2 = {ram2, vram2, fw2, rom2, vec2, unm2, 8'h00, io2};

    function automatic logic [21:0] model_sel(input logic [15:0] a, input int ioc);
        logic [21:0] r;
        int off;
        r = '0;
        off = int'(a) - 'h7000;
        if (a <= 16'h36ff)      r[21] = 1'b1;
        else if (a <= 16'h3fff) r[20] = 1'b1;
        else if (a <= 16'h6fff) r[19] = 1'b1;
        else if (a < 16'h8000) begin
            if (off < ioc) r[off] = 1'b1;
            else           r[16]  = 1'b1;
        end else begin
            r[18] = 1'b1;
            if (a >= 16'hfffa) r[17] = 1'b1;
        end
        return r;
    endfunction

    function automatic int model_ws(input logic [15:0] a, input int ioc, input int wsio);
        logic [21:0] s;
        s = model_sel(a, ioc);
        if (s[21]) return 0;
        if (s[20]) return 1;
        if (s[19]) return 0;
        if (s[18]) return 2;
        if (s[16]) return 0;
        return wsio;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("sel_dut", {10'h0, got1}, {10'h0, model_sel(addr1, 4)});
        chk("sel_dut8", {10'h0, got2}, {10'h0, model_sel(addr2, 8)});
        if (rst || !valid1) chk("rdy_idle_dut", {31'h0, rdy1}, 32'd1);
        if (rst || !valid2) chk("rdy_idle_dut8", {31'h0, rdy2}, 32'd1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds the address until the DUT reports completion, counting stall cycles.
    task automatic access(input int which, input logic [15:0] a, input int exp_lows, input string name);
        int lows;
        bit done;
        logic r;
        lows = 0;
        done = 1'b0;
        if (which == 0) begin addr1 = a; valid1 = 1'b1; end
        else            begin addr2 = a; valid2 = 1'b1; end
        for (int c = 0; c < 12 && !done; c++) begin
            @(negedge clk);
            r = (which == 0) ? rdy1 : rdy2;
            if (r) done = 1'b1;
            else   lows++;
            step();
        end
        chk({name, "_done"}, {31'h0, done}, 32'd1);
        chk({name, "_stalls"}, lows, exp_lows);
    endtask

    task automatic idle(input int n);
        valid1 = 1'b0;
        valid2 = 1'b0;
        for (int k = 0; k < n; k++) begin
            addr1 = 16'($urandom);
            addr2 = 16'($urandom);
            step();
        end
    endtask

    function automatic logic [15:0] rand_addr();
        case ($urandom % 8)
            0: return 16'($urandom_range(16'h0000, 16'h36ff));
            1: return 16'($urandom_range(16'h3700, 16'h3fff));
            2: return 16'($urandom_range(16'h4000, 16'h6fff));
            3: return 16'($urandom_range(16'h7000, 16'h700f));
            4: return 16'($urandom_range(16'h7010, 16'h7fff));
            5: return 16'($urandom_range(16'h8000, 16'hffff));
            6: return 16'($urandom_range(16'hfff0, 16'hffff));
            default: return 16'($urandom);
        endcase
    endfunction

    logic [15:0] sw_addr [16] = '{16'h0000, 16'h36ff, 16'h3700, 16'h3fff, 16'h4000, 16'h6fff,
                                  16'h7000, 16'h7001, 16'h7002, 16'h7003, 16'h7004, 16'h7fff,
                                  16'h8000, 16'hfff9, 16'hfffa, 16'hffff};
    logic [21:0] sw_exp [16] = '{{6'b100000, 16'h0}, {6'b100000, 16'h0}, {6'b010000, 16'h0},
                                 {6'b010000, 16'h0}, {6'b001000, 16'h0}, {6'b001000, 16'h0},
                                 {6'b000000, 16'h1}, {6'b000000, 16'h2}, {6'b000000, 16'h4},
                                 {6'b000000, 16'h8}, {6'b000001, 16'h0}, {6'b000001, 16'h0},
                                 {6'b000100, 16'h0}, {6'b000100, 16'h0}, {6'b000110, 16'h0},
                                 {6'b000110, 16'h0}};

    initial begin
        logic [15:0] a;
        int which;
        rst    = 1'b1;
        valid1 = 1'b1;
        valid2 = 1'b0;
        addr1  = 16'h8000;
        addr2  = 16'h0000;
`ifdef ADDRESS_BUS_WS_BUS_ERROR_EN
        clr = 1'b0;
`endif
        #1;
        repeat (3) begin
            @(negedge clk);
            chk("reset_rdy", {31'h0, rdy1}, 32'd1);
        end
        step();
        rst = 1'b0;
        valid1 = 1'b0;
`ifdef ADDRESS_BUS_WS_BUS_ERROR_EN
        @(negedge clk);
        chk("reset_irq", {31'h0, irq1}, 32'd0);
        chk("reset_eaddr", {16'h0, eaddr1}, 32'd0);
        step();
`endif

        for (int i = 0; i < 16; i++) begin
            addr1 = sw_addr[i];
            @(negedge clk);
            chk($sformatf("sweep_%04h", sw_addr[i]), {10'h0, got1}, {10'h0, sw_exp[i]});
            step();
        end

        access(0, 16'h3800, 1, "vram");
        idle(1);
        access(0, 16'h8000, 2, "rom");
        idle(1);
        for (int i = 0; i < 3; i++) access(0, 16'h0000, 0, "ram");
        idle(1);
        access(0, 16'h8000, 2, "rom_b2b_a");
        access(0, 16'h8000, 2, "rom_b2b_b");
        idle(2);

        addr1  = 16'h8000;
        valid1 = 1'b1;
        @(negedge clk);
        chk("rst_pre_rdy", {31'h0, rdy1}, 32'd0);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_rdy", {31'h0, rdy1}, 32'd1);
        step();
        rst = 1'b0;
        access(0, 16'h8000, 2, "rom_after_rst");
        idle(1);

`ifdef ADDRESS_BUS_WS_BUS_ERROR_EN
        access(0, 16'h7010, 0, "err_a");
        idle(0);
        @(negedge clk);
        chk("err_irq_a", {31'h0, irq1}, 32'd1);
        chk("err_addr_a", {16'h0, eaddr1}, 32'h7010);
        step();
        access(0, 16'h7020, 0, "err_b");
        valid1 = 1'b0;
        @(negedge clk);
        chk("err_addr_kept", {16'h0, eaddr1}, 32'h7010);
        step();
        clr = 1'b1;
        access(0, 16'h7030, 0, "err_c");
        clr = 1'b0;
        valid1 = 1'b0;
        @(negedge clk);
        chk("err_irq_setwins", {31'h0, irq1}, 32'd1);
        chk("err_addr_new", {16'h0, eaddr1}, 32'h7030);
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        @(negedge clk);
        chk("err_irq_cleared", {31'h0, irq1}, 32'd0);
        step();
`endif

        addr2 = 16'h7007;
        @(negedge clk);
        chk("io8_bit7", {31'h0, io2[7]}, 32'd1);
        step();
        access(1, 16'h7007, 3, "io8_7007");
        idle(1);
        access(1, 16'h7003, 3, "io8_7003");
        access(1, 16'h7008, 0, "io8_unmapped");
        idle(1);

        for (int n = 0; n < 400; n++) begin
            idle($urandom_range(0, 2));
            a = rand_addr();
            which = int'($urandom % 2);
            if (which == 0) access(0, a, model_ws(a, 4, 0), "rnd_dut");
            else            access(1, a, model_ws(a, 8, 3), "rnd_dut8");
        end
        idle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
